// File: rtl/tl_fifo_order_fixer.sv
// TileLink-UL A/D adapter that holds a source's new request while it still has responses pending from a different FIFO domain.
// Zero-latency combinational data path; optional underflow checker enabled by TL_FIFO_FIXER_CHECK_EN.
module tl_fifo_order_fixer #(
  parameter int SOURCE_W   = 7,
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 64,
  parameter int DOMAIN_LSB = 24,
  parameter int DOMAIN_W   = 2,
  parameter int FLIGHT_W   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  auto_in_a_valid,
  output logic                  auto_in_a_ready,
  input  logic [2:0]            auto_in_a_bits_opcode,
  input  logic [2:0]            auto_in_a_bits_param,
  input  logic [2:0]            auto_in_a_bits_size,
  input  logic [SOURCE_W-1:0]   auto_in_a_bits_source,
  input  logic [ADDR_W-1:0]     auto_in_a_bits_address,
  input  logic [DATA_W/8-1:0]   auto_in_a_bits_mask,
  input  logic [DATA_W-1:0]     auto_in_a_bits_data,
  input  logic                  auto_in_a_bits_corrupt,
  output logic                  auto_out_a_valid,
  input  logic                  auto_out_a_ready,
  output logic [2:0]            auto_out_a_bits_opcode,
  output logic [2:0]            auto_out_a_bits_param,
  output logic [2:0]            auto_out_a_bits_size,
  output logic [SOURCE_W-1:0]   auto_out_a_bits_source,
  output logic [ADDR_W-1:0]     auto_out_a_bits_address,
  output logic [DATA_W/8-1:0]   auto_out_a_bits_mask,
  output logic [DATA_W-1:0]     auto_out_a_bits_data,
  output logic                  auto_out_a_bits_corrupt,
  input  logic                  auto_out_d_valid,
  output logic                  auto_out_d_ready,
  input  logic [2:0]            auto_out_d_bits_opcode,
  input  logic [2:0]            auto_out_d_bits_size,
  input  logic [SOURCE_W-1:0]   auto_out_d_bits_source,
  input  logic [DATA_W-1:0]     auto_out_d_bits_data,
  output logic                  auto_in_d_valid,
  input  logic                  auto_in_d_ready,
  output logic [2:0]            auto_in_d_bits_opcode,
  output logic [2:0]            auto_in_d_bits_size,
  output logic [SOURCE_W-1:0]   auto_in_d_bits_source,
  output logic [DATA_W-1:0]     auto_in_d_bits_data
`ifdef TL_FIFO_FIXER_CHECK_EN
  ,
  output logic                  err_underflow
`endif
);

  localparam int NSRC   = 1 << SOURCE_W;
  localparam int LGB    = $clog2(DATA_W / 8);
  localparam int BEAT_W = 8;

  logic [FLIGHT_W-1:0] r_cnt [NSRC];
  logic [DOMAIN_W-1:0] r_dom [NSRC];
  logic [BEAT_W-1:0]   r_a_rem;
  logic [BEAT_W-1:0]   r_d_rem;

  logic                w_a_first;
  logic                w_d_first;
  logic [DOMAIN_W-1:0] w_req_dom;
  logic [FLIGHT_W-1:0] w_cnt_a;
  logic [DOMAIN_W-1:0] w_dom_a;
  logic [FLIGHT_W-1:0] w_cnt_d;
  logic                w_stall;
  logic                w_a_fire;
  logic                w_d_fire;
  logic                w_a_inc;
  logic                w_d_first_fire;
  logic                w_d_dec;
  logic [BEAT_W-1:0]   w_a_beats_m1;
  logic [BEAT_W-1:0]   w_d_beats_m1;

  // Remaining beats after the first one; only data-carrying messages can burst.
  function automatic logic [BEAT_W-1:0] beats_m1(input logic burst, input logic [2:0] size);
    logic [BEAT_W-1:0] v;
    v = '0;
    if (burst && (int'(size) > LGB))
      v = ((BEAT_W'(1) << size) >> LGB) - BEAT_W'(1);
    return v;
  endfunction

  assign w_a_first    = (r_a_rem == '0);
  assign w_d_first    = (r_d_rem == '0);
  assign w_req_dom    = auto_in_a_bits_address[DOMAIN_LSB +: DOMAIN_W];
  assign w_cnt_a      = r_cnt[auto_in_a_bits_source];
  assign w_dom_a      = r_dom[auto_in_a_bits_source];
  assign w_cnt_d      = r_cnt[auto_out_d_bits_source];
  assign w_a_beats_m1 = beats_m1(auto_in_a_bits_opcode <= 3'd1, auto_in_a_bits_size);
  assign w_d_beats_m1 = beats_m1(auto_out_d_bits_opcode == 3'd1, auto_out_d_bits_size);

  // Only the first beat can stall, and the decision never looks at out_a_ready.
  assign w_stall = w_a_first &
                   (((w_cnt_a != '0) && (w_dom_a != w_req_dom)) || (w_cnt_a == '1));

  assign auto_out_a_valid = auto_in_a_valid & ~w_stall;
  assign auto_in_a_ready  = auto_out_a_ready & ~w_stall;

  assign w_a_fire       = auto_in_a_valid & auto_out_a_ready & ~w_stall;
  assign w_d_fire       = auto_out_d_valid & auto_in_d_ready;
  assign w_a_inc        = w_a_fire & w_a_first;
  assign w_d_first_fire = w_d_fire & w_d_first;
  assign w_d_dec        = w_d_first_fire & (w_cnt_d != '0);

  assign auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
  assign auto_out_a_bits_param   = auto_in_a_bits_param;
  assign auto_out_a_bits_size    = auto_in_a_bits_size;
  assign auto_out_a_bits_source  = auto_in_a_bits_source;
  assign auto_out_a_bits_address = auto_in_a_bits_address;
  assign auto_out_a_bits_mask    = auto_in_a_bits_mask;
  assign auto_out_a_bits_data    = auto_in_a_bits_data;
  assign auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;

  assign auto_in_d_valid       = auto_out_d_valid;
  assign auto_out_d_ready      = auto_in_d_ready;
  assign auto_in_d_bits_opcode = auto_out_d_bits_opcode;
  assign auto_in_d_bits_size   = auto_out_d_bits_size;
  assign auto_in_d_bits_source = auto_out_d_bits_source;
  assign auto_in_d_bits_data   = auto_out_d_bits_data;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_a_rem <= '0;
      r_d_rem <= '0;
      for (int i = 0; i < NSRC; i++) begin
        r_cnt[i] <= '0;
        r_dom[i] <= '0;
      end
    end else begin
      if (w_a_fire)
        r_a_rem <= w_a_first ? w_a_beats_m1 : (r_a_rem - BEAT_W'(1));
      if (w_d_fire)
        r_d_rem <= w_d_first ? w_d_beats_m1 : (r_d_rem - BEAT_W'(1));
      if (w_a_inc)
        r_dom[auto_in_a_bits_source] <= w_req_dom;
      // Same-source request and response in one cycle cancel out.
      if (!(w_a_inc && w_d_dec && (auto_in_a_bits_source == auto_out_d_bits_source))) begin
        if (w_a_inc)
          r_cnt[auto_in_a_bits_source] <= w_cnt_a + FLIGHT_W'(1);
        if (w_d_dec)
          r_cnt[auto_out_d_bits_source] <= w_cnt_d - FLIGHT_W'(1);
      end
    end
  end

`ifdef TL_FIFO_FIXER_CHECK_EN
  logic w_underflow;
  logic r_err_underflow;

  assign w_underflow   = w_d_first_fire & (w_cnt_d == '0);
  assign err_underflow = r_err_underflow;

  always_ff @(posedge clock) begin
    if (!reset)
      r_err_underflow <= 1'b0;
    else if (w_underflow)
      r_err_underflow <= 1'b1;
  end

`ifndef SYNTHESIS
`ifdef PRINTF_COND_
  always @(posedge clock) begin
    if (reset && w_underflow)
      $error("tl_fifo_order_fixer: D response for source %0d with nothing in flight",
             auto_out_d_bits_source);
  end
`endif
`endif
`endif

endmodule

// File: tb/tb_tl_fifo_order_fixer.sv
// Bench for tl_fifo_order_fixer: directed scenarios then random traffic against a per-source in-flight queue model.
module tb_tl_fifo_order_fixer;
  localparam int NSRC = 128;
  localparam int MAXF = 15;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        a_valid, a_corrupt, out_a_ready, d_valid, in_d_ready;
  logic [2:0]  a_opcode, a_param, a_size, d_opcode, d_size;
  logic [6:0]  a_source, d_source;
  logic [28:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data, d_data;

  logic        o_in_a_ready, o_out_a_valid, o_out_a_corrupt, o_out_d_ready, o_in_d_valid;
  logic [2:0]  o_out_a_opcode, o_out_a_param, o_out_a_size, o_in_d_opcode, o_in_d_size;
  logic [6:0]  o_out_a_source, o_in_d_source;
  logic [28:0] o_out_a_address;
  logic [7:0]  o_out_a_mask;
  logic [63:0] o_out_a_data, o_in_d_data;
`ifdef TL_FIFO_FIXER_CHECK_EN
  logic        err_underflow;
`endif

  tl_fifo_order_fixer dut (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(a_valid), .auto_in_a_ready(o_in_a_ready),
    .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
    .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
    .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
    .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
    .auto_out_a_valid(o_out_a_valid), .auto_out_a_ready(out_a_ready),
    .auto_out_a_bits_opcode(o_out_a_opcode), .auto_out_a_bits_param(o_out_a_param),
    .auto_out_a_bits_size(o_out_a_size), .auto_out_a_bits_source(o_out_a_source),
    .auto_out_a_bits_address(o_out_a_address), .auto_out_a_bits_mask(o_out_a_mask),
    .auto_out_a_bits_data(o_out_a_data), .auto_out_a_bits_corrupt(o_out_a_corrupt),
    .auto_out_d_valid(d_valid), .auto_out_d_ready(o_out_d_ready),
    .auto_out_d_bits_opcode(d_opcode), .auto_out_d_bits_size(d_size),
    .auto_out_d_bits_source(d_source), .auto_out_d_bits_data(d_data),
    .auto_in_d_valid(o_in_d_valid), .auto_in_d_ready(in_d_ready),
    .auto_in_d_bits_opcode(o_in_d_opcode), .auto_in_d_bits_size(o_in_d_size),
    .auto_in_d_bits_source(o_in_d_source), .auto_in_d_bits_data(o_in_d_data)
`ifdef TL_FIFO_FIXER_CHECK_EN
    , .err_underflow(err_underflow)
`endif
  );

  typedef struct packed {
    logic [1:0] dom;
    logic [2:0] op;
    logic [2:0] size;
  } req_t;

  // Reference: every request still awaiting its response, per source, in issue order.
  req_t q [NSRC][$];
  int   a_rem, d_rem;
  bit   exp_err;
  bit   last_a_fire, last_d_fire;
  int   checks = 0;
  int   failures = 0;

  function automatic int beats(input bit burst, input int size);
    if (burst && size > 3) return (1 << size) / 8;
    return 1;
  endfunction

  function automatic bit model_stall();
    int s;
    int dom;
    if (a_rem != 0) return 1'b0;
    s   = int'(a_source);
    dom = int'(a_address[25:24]);
    if (q[s].size() >= MAXF) return 1'b1;
    foreach (q[s][i]) if (int'(q[s][i].dom) != dom) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input bit v, input int op, input int size, input int src, input int dom);
    a_valid   = v;
    a_opcode  = 3'(op);
    a_param   = 3'($urandom_range(0, 7));
    a_size    = 3'(size);
    a_source  = 7'(src);
    a_address = 29'($urandom);
    a_address[25:24] = 2'(dom);
    a_mask    = 8'($urandom);
    a_data    = {$urandom, $urandom};
    a_corrupt = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_d(input bit v, input int op, input int size, input int src);
    d_valid  = v;
    d_opcode = 3'(op);
    d_size   = 3'(size);
    d_source = 7'(src);
    d_data   = {$urandom, $urandom};
  endtask

  // Called just after a falling edge with inputs set; checks, then advances one clock.
  task automatic cycle();
    bit stall;
    bit af, df;
    #1;
    stall = model_stall();
    check("out_a_valid", 128'(o_out_a_valid), 128'(a_valid && !stall));
    check("in_a_ready", 128'(o_in_a_ready), 128'(out_a_ready && !stall));
    check("a_bits", 128'({o_out_a_opcode, o_out_a_param, o_out_a_size, o_out_a_source,
                          o_out_a_address, o_out_a_mask, o_out_a_corrupt, o_out_a_data}),
                    128'({a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data}));
    check("d_hs", 128'({o_in_d_valid, o_out_d_ready}), 128'({d_valid, in_d_ready}));
    check("d_bits", 128'({o_in_d_opcode, o_in_d_size, o_in_d_source, o_in_d_data}),
                    128'({d_opcode, d_size, d_source, d_data}));
`ifdef TL_FIFO_FIXER_CHECK_EN
    check("err_underflow", 128'(err_underflow), 128'(exp_err));
`endif
    af = a_valid && !stall && out_a_ready;
    df = d_valid && in_d_ready;
    @(posedge clock);
    if (!reset) begin
      foreach (q[i]) q[i].delete();
      a_rem = 0; d_rem = 0; exp_err = 1'b0;
      af = 1'b0; df = 1'b0;
    end else begin
      if (df) begin
        if (d_rem == 0) begin
          if (q[int'(d_source)].size() > 0) void'(q[int'(d_source)].pop_front());
          else exp_err = 1'b1;
          d_rem = beats(d_opcode == 3'd1, int'(d_size)) - 1;
        end else d_rem--;
      end
      if (af) begin
        if (a_rem == 0) begin
          q[int'(a_source)].push_back('{dom: a_address[25:24], op: a_opcode, size: a_size});
          a_rem = beats(a_opcode <= 3'd1, int'(a_size)) - 1;
        end else a_rem--;
      end
    end
    last_a_fire = af;
    last_d_fire = df;
    @(negedge clock);
  endtask

  task automatic issue_a(input int op, input int size, input int src, input int dom);
    int n;
    for (int b = 0; b < beats(op <= 1, size); b++) begin
      drive_a(1'b1, op, size, src, dom);
      n = 0;
      cycle();
      while (!last_a_fire && n < 60) begin cycle(); n++; end
      check("a_fire_in_budget", 128'(last_a_fire), 128'(1));
    end
    a_valid = 1'b0;
  endtask

  task automatic respond(input int src, input int op, input int size);
    int n;
    for (int b = 0; b < beats(op == 1, size); b++) begin
      drive_d(1'b1, op, size, src);
      n = 0;
      cycle();
      while (!last_d_fire && n < 60) begin cycle(); n++; end
      check("d_fire_in_budget", 128'(last_d_fire), 128'(1));
    end
    d_valid = 1'b0;
  endtask

  int a_left, d_left, pending;

  initial begin
    reset = 1'b0;
    out_a_ready = 1'b1;
    in_d_ready  = 1'b1;
    drive_a(1'b0, 4, 3, 0, 0);
    drive_d(1'b0, 1, 3, 0);
    a_rem = 0; d_rem = 0; exp_err = 1'b0;
    @(negedge clock);
    // In reset with nothing tracked, A passes straight through.
    drive_a(1'b1, 4, 3, 0, 2);
    cycle();
    a_valid = 1'b0;
    reset = 1'b1;
    cycle();

    // Single Get and its AccessAckData; a different domain then proceeds freely.
    issue_a(4, 3, 5, 1);
    respond(5, 1, 3);
    issue_a(4, 3, 5, 2);
    respond(5, 1, 3);

    // Cross-domain request held until the outstanding response drains.
    issue_a(4, 3, 3, 1);
    drive_a(1'b1, 4, 3, 3, 2);
    repeat (3) cycle();
    check("t2_held", 128'(last_a_fire), 128'(0));
    drive_d(1'b1, 1, 3, 3);
    cycle();
    d_valid = 1'b0;
    cycle();
    check("t2_issued_after_d", 128'(last_a_fire), 128'(1));
    a_valid = 1'b0;
    respond(3, 1, 3);

    // Same-domain back-to-back requests.
    issue_a(4, 3, 3, 1);
    issue_a(4, 3, 3, 1);
    respond(3, 1, 3);
    respond(3, 1, 3);

    // Put burst: later beats carry a conflicting domain yet never stall.
    issue_a(4, 3, 7, 1);
    drive_a(1'b1, 0, 5, 7, 1);
    cycle();
    for (int b = 0; b < 3; b++) begin
      drive_a(1'b1, 0, 5, 7, 2);
      cycle();
    end
    a_valid = 1'b0;
    respond(7, 1, 3);
    respond(7, 0, 5);
    issue_a(4, 3, 7, 2);
    respond(7, 1, 3);
    issue_a(4, 5, 7, 2);
    respond(7, 1, 5);
    issue_a(4, 3, 7, 3);
    respond(7, 1, 3);

    // Fill source 0 to the in-flight limit.
    for (int i = 0; i < MAXF; i++) issue_a(4, 3, 0, 0);
    drive_a(1'b1, 4, 3, 0, 0);
    repeat (3) cycle();
    check("t5_full_held", 128'(last_a_fire), 128'(0));
    drive_d(1'b1, 1, 3, 0);
    cycle();
    d_valid = 1'b0;
    cycle();
    a_valid = 1'b0;
    respond(0, 1, 3);
    drive_a(1'b1, 4, 3, 0, 0);
    drive_d(1'b1, 1, 3, 0);
    cycle();
    check("t5_same_cycle_ad", 128'({last_a_fire, last_d_fire}), 128'(2'b11));
    d_valid = 1'b0;
    drive_a(1'b1, 4, 3, 0, 0);
    cycle();
    drive_a(1'b1, 4, 3, 0, 0);
    repeat (2) cycle();
    a_valid = 1'b0;
    for (int i = 0; i < MAXF; i++) respond(0, 1, 3);

`ifdef TL_FIFO_FIXER_CHECK_EN
    // Response with nothing in flight: sticky error from the next cycle.
    respond(9, 1, 3);
    repeat (3) cycle();
`endif

    // Random traffic over a few sources; the last stretch only drains.
    a_left = 0; d_left = 0;
    for (int it = 0; it < 1500; it++) begin
      if (!a_valid && it < 500 && $urandom_range(0, 9) < 6) begin
        int op;
        op = ($urandom_range(0, 1) == 1) ? 4 : 0;
        drive_a(1'b1, op, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3));
        a_left = beats(op <= 1, int'(a_size));
      end
      if (!d_valid && d_rem == 0) begin
        int s;
        s = $urandom_range(0, 3);
        if (q[s].size() > 0 && $urandom_range(0, 1) == 1) begin
          int op;
          op = (q[s][0].op == 3'd4) ? 1 : 0;
          drive_d(1'b1, op, int'(q[s][0].size), s);
          d_left = beats(op == 1, int'(q[s][0].size));
        end
      end
      out_a_ready = ($urandom_range(0, 3) != 0);
      in_d_ready  = ($urandom_range(0, 9) < 7);
      cycle();
      if (last_a_fire) begin
        a_left--;
        if (a_left == 0) a_valid = 1'b0;
        else a_data = {$urandom, $urandom};
      end
      if (last_d_fire) begin
        d_left--;
        if (d_left == 0) d_valid = 1'b0;
        else d_data = {$urandom, $urandom};
      end
    end
    pending = 0;
    foreach (q[i]) pending += q[i].size();
    check("random_drained", 128'({a_valid, d_valid, 32'(pending)}), 128'(0));

    // Reset clears tracking (and the sticky error).
    out_a_ready = 1'b1;
    in_d_ready  = 1'b1;
    a_valid = 1'b0;
    d_valid = 1'b0;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    issue_a(4, 3, 3, 2);
    respond(3, 1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
